// File: rtl/vexriscv_bridge_pkg.sv
// Shared definitions for the VexRiscv dBus to AXI4-Lite bridge.
//   - bridge FSM state encoding
//   - AXI response codes
//   - size_addr_to_strb(): byte-lane strobe for a dBus access of a given size/offset
package vexriscv_bridge_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StRdAddr = 3'd1;
  localparam state_t StRdData = 3'd2;
  localparam state_t StWrReq  = 3'd3;
  localparam state_t StWrResp = 3'd4;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  // Byte: one lane at the offset. Half: lower or upper lane pair. Word (and 3): all lanes.
  function automatic logic [3:0] size_addr_to_strb(input logic [1:0] size,
                                                   input logic [1:0] addr);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr;
      2'd1:    strb = 4'b0011 << {addr[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Both SLVERR and DECERR have bit 1 set; decoded explicitly so every resp bit is consumed.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp == RespSlverr) || (resp == RespDecerr);
  endfunction

endpackage

// File: rtl/vexriscv_dbus_axil_bridge.sv
// VexRiscv simple dBus (cmd/rsp) to single-outstanding AXI4-Lite master.
//   clk, arst            : core clock, asynchronous active-low reset
//   dBus_cmd_*           : command from the core; accepted only when idle
//   dBus_rsp_*           : one-cycle read response (data + error)
//   m_aw*/m_w*/m_b*      : AXI4-Lite write channels
//   m_ar*/m_r*           : AXI4-Lite read channels
//   wr_err               : one-cycle pulse when a posted write returns SLVERR/DECERR
// Writes are posted: the core never sees a dBus response for them.
module vexriscv_dbus_axil_bridge
  import vexriscv_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic                  clk,
  input  logic                  arst,

  input  logic                  dBus_cmd_valid,
  output logic                  dBus_cmd_ready,
  input  logic                  dBus_cmd_payload_wr,
  input  logic [31:0]           dBus_cmd_payload_address,
  input  logic [31:0]           dBus_cmd_payload_data,
  input  logic [1:0]            dBus_cmd_payload_size,
  output logic                  dBus_rsp_ready,
  output logic                  dBus_rsp_error,
  output logic [31:0]           dBus_rsp_data,

  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,

  output logic                  wr_err
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              strb_q, strb_d;
  logic                    aw_pend_q, aw_pend_d;
  logic                    w_pend_q, w_pend_d;
  logic                    rsp_ready_q, rsp_ready_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [31:0]             rsp_data_q, rsp_data_d;
  logic                    wr_err_q, wr_err_d;
  logic [ADDR_WIDTH-1:0]   addr_ext;

  // Fit the 32-bit core address onto the AXI address bus.
  if (ADDR_WIDTH > 32) begin : g_addr_zext
    assign addr_ext = {{(ADDR_WIDTH - 32){1'b0}}, dBus_cmd_payload_address};
  end else if (ADDR_WIDTH == 32) begin : g_addr_same
    assign addr_ext = dBus_cmd_payload_address;
  end else begin : g_addr_trunc
    assign addr_ext = dBus_cmd_payload_address[ADDR_WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    rsp_ready_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    wr_err_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (dBus_cmd_valid) begin
          addr_d  = addr_ext;
          wdata_d = dBus_cmd_payload_data;
          strb_d  = size_addr_to_strb(dBus_cmd_payload_size, dBus_cmd_payload_address[1:0]);
          if (dBus_cmd_payload_wr) begin
            state_d   = StWrReq;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end else begin
            state_d = StRdAddr;
          end
        end
      end
      StRdAddr: begin
        if (m_arready) state_d = StRdData;
      end
      StRdData: begin
        if (m_rvalid) begin
          rsp_data_d  = m_rdata;
          rsp_err_d   = resp_is_error(m_rresp);
          rsp_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StWrReq: begin
        // AW and W complete independently; move on once both have handshaken.
        if (m_awready) aw_pend_d = 1'b0;
        if (m_wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (m_bvalid) begin
          wr_err_d = resp_is_error(m_bresp);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      rsp_ready_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign dBus_cmd_ready = (state_q == StIdle);
  assign dBus_rsp_ready = rsp_ready_q;
  assign dBus_rsp_error = rsp_err_q;
  assign dBus_rsp_data  = rsp_data_q;

  assign m_awaddr  = addr_q;
  assign m_awprot  = AXI_PROT;
  assign m_awvalid = aw_pend_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = strb_q;
  assign m_wvalid  = w_pend_q;
  assign m_bready  = (state_q == StWrResp);
  assign m_araddr  = addr_q;
  assign m_arprot  = AXI_PROT;
  assign m_arvalid = (state_q == StRdAddr);
  assign m_rready  = (state_q == StRdData);

  assign wr_err = wr_err_q;

endmodule
